uart_alu_interface: RTL

Frame sequencer between the UART receiver/transmitter and the combinational ALU. It collects three received bytes in order: operand A, operand B, opcode. It drives them onto the ALU inputs, captures the ALU result and hands it to the UART transmitter as a single byte, then waits for transmit completion before accepting the next frame. An inter-byte timeout discards incomplete frames.

---
 rtl/uart_alu_interface.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_alu_interface.sv
// Frame sequencer: gathers operand A, operand B and opcode bytes from the UART,
// presents them to an external combinational ALU and ships the result byte back out.
module uart_alu_interface #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [DATA_WIDTH-1:0] o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_rx_overrun
);

    // A zero timeout disables expiry; keep the counter at least one bit wide.
    localparam bit TO_EN    = (TIMEOUT_CYCLES > 0);
    localparam int CW       = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST     = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, op_q, op_d, tx_q, tx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  to_q, to_d, ovr_q, ovr_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tx_q    <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    a_d     = i_rx_data;
                    cnt_d   = '0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    b_d     = i_rx_data;
                    cnt_d   = '0;
                    state_d = WAIT_OP;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_OP: begin
                // A byte arriving on the expiry cycle still completes the frame.
                if (i_rx_done) begin
                    op_d    = i_rx_data;
                    state_d = EXEC;
                end else if (TO_EN && cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EXEC: begin
                tx_d    = i_alu_result;
                ovr_d   = i_rx_done;
                state_d = SEND;
            end
            SEND: begin
                ovr_d   = i_rx_done;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                ovr_d = i_rx_done;
                if (i_tx_done) state_d = WAIT_A;
            end
            default: state_d = WAIT_A;
        endcase
    end

    // tx_start decodes the state so an async reset removes it immediately.
    assign o_tx_start   = (state_q == SEND);
    assign o_busy       = (state_q != WAIT_A);
    assign o_alu_a      = a_q;
    assign o_alu_b      = b_q;
    assign o_alu_op     = op_q;
    assign o_tx_data    = tx_q;
    assign o_timeout    = to_q;
    assign o_rx_overrun = ovr_q;

endmodule
